shift_counter_n: RTL and testbench
==================================

# shift_counter_n

Parametrised, mode-selectable shift register / ring counter for the lab sequential-logic library. It generalises the fixed 4-bit serial-in shifter to a WIDTH-bit register supporting:
- hold, shift up, shift down and parallel load;
- ring rotation in both directions and Johnson (twisted-ring) counting.

A rotation step counter and a wrap pulse let downstream sequencers (LED scanners, step-motor phase drivers) detect full cycles.

## Interface
- WIDTH, 4: register width; legal range 2..32.
- RESET_VAL, {1'b1, {(WIDTH-1){1'b0}}} (4'b1000 at default): value loaded into q on reset.
- SW, $clog2(2*WIDTH): step counter width (localparam, not overridable).
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  step enable; when low, all state holds.
- mode  input  3  operation select (see Operation).
- sin_up  input  1  serial input entering q[0] on shift up.
- sin_dn  input  1  serial input entering q[WIDTH-1] on shift down.
- load_val  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents (registered).
- sout_up  output  1  q[WIDTH-1] (combinational from q).
- sout_dn  output  1  q[0] (combinational from q).
- step  output  SW  rotation steps since last clear (registered).
- wrap  output  1  one-cycle pulse on completion of a full rotation period (registered).
- illegal  output  1  sticky flag: reserved mode used while en=1 (registered).

## Operation
- Reset values:
  - q = RESET_VAL.
  - step = 0, wrap = 0, illegal = 0.
  - last_rot = none.
- Reset has priority over en and mode.
- en=0: q, step, illegal and last_rot hold; wrap = 0.
- en=1, mode decode:
  - 000 HOLD: q holds; step holds.
  - 001 SHUP: q <= {q[WIDTH-2:0], sin_up}; step <= 0.
  - 010 SHDN: q <= {sin_dn, q[WIDTH-1:1]}; step <= 0.
  - 011 LOAD: q <= load_val; step <= 0.
  - 100 ROTUP: q <= {q[WIDTH-2:0], q[WIDTH-1]}; period P = WIDTH.
  - 101 ROTDN: q <= {q[0], q[WIDTH-1:1]}; P = WIDTH.
  - 110 JOHN: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; P = 2*WIDTH.
  - 111 reserved: q and step hold; illegal <= 1 (sticky until reset).
- Rotation step rules (modes 100/101/110):
  - If mode ≠ last_rot: step <= 1, wrap <= 0, last_rot <= mode. This first step counts.
  - Else if step == P-1: step <= 0, wrap <= 1.
  - Else: step <= step+1.
- last_rot is cleared to none by SHUP, SHDN, LOAD and reset. HOLD and reserved leave it unchanged.
- wrap = 0 in every cycle not covered by the rollover rule.
- Wrap-around property: starting from any value after a clear, after exactly P consecutive steps in the same rotation mode, q equals the value held at the clear and wrap = 1 on that same cycle.
- Shift outputs: sout_up and sout_dn always reflect the current q. On a shift, the bit shifted out is the one visible on sout_up/sout_dn in the cycle before the clock edge.

## Timing
- All state updates on rising clk. q, step, wrap and illegal change together, one cycle after the controlling inputs are sampled.
- Latency: mode/en/data sampled at edge N → q valid after edge N.
- wrap is high for exactly one cycle, aligned with the q value that completes the period.
- HOLD or en=0 cycles between rotation steps do not reset step; counting resumes.
- Reset mid-rotation:
  - Takes effect at the next edge: q = RESET_VAL, step = 0, wrap = 0.
  - A pending rollover is lost.
- Changing between rotation modes mid-period restarts the count at 1. No wrap is generated for the abandoned period.
- No combinational path from inputs to outputs.

## Test plan
- Reset defaults: WIDTH=4, reset=1 for 2 cycles → q=1000, step=0, wrap=0, illegal=0.
- Shift up with pattern: en=1, mode=001, sin_up=1,0,1,1 on successive cycles from q=1000 → q=0001, 0010, 0101, 1011; step stays 0.
- Ring wrap: from q=1000, ROTUP for 4 cycles → q=0001, 0010, 0100, 1000; step=1, 2, 3, 0; wrap=1 only on the 4th cycle. Repeat with ROTDN → 0100, 0010, 0001, 1000.
- Johnson with stall: LOAD 0000, then JOHN for 8 steps with en=0 inserted after step 3. Required sequence: q=0001, 0011, 0111, (hold 0111, wrap=0), 1111, 1110, 1100, 1000, 0000. wrap=1 only on the 0000 cycle; step = 0 at end.
- Mode switch and reset mid-operation:
  - ROTUP 2 steps, then JOHN 1 step → step=1, no wrap.
  - Assert reset during the next JOHN step → q=1000, step=0, wrap=0.
- Reserved mode and parameter sweep:
  - mode=111 with en=1 → q unchanged, illegal=1, and illegal stays 1 through later modes until reset.
  - Rerun the ring-wrap test at WIDTH=8: wrap after 8 steps; Johnson period 16.

Source files
------------

// File: rtl/shift_counter_n.sv
// shift_counter_n
//   WIDTH-bit register that can hold, shift, parallel-load, rotate in either
//   direction or count as a Johnson (twisted-ring) counter. A rotation step
//   counter and a one-cycle wrap pulse mark full rotation periods.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   en        step enable; low holds all state (wrap drops)
//   mode      operation select (HOLD/SHUP/SHDN/LOAD/ROTUP/ROTDN/JOHN/reserved)
//   sin_up    serial input into q[0] on shift up
//   sin_dn    serial input into q[WIDTH-1] on shift down
//   load_val  parallel load data
//   q         registered register contents
//   sout_up   q[WIDTH-1]
//   sout_dn   q[0]
//   step      rotation steps since last clear
//   wrap      one-cycle pulse when a full rotation period completes
//   illegal   sticky flag, reserved mode seen while enabled
module shift_counter_n #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic                          sin_up,
    input  logic                          sin_dn,
    input  logic [WIDTH-1:0]              load_val,
    output logic [WIDTH-1:0]              q,
    output logic                          sout_up,
    output logic                          sout_dn,
    output logic [$clog2(2*WIDTH)-1:0]    step,
    output logic                          wrap,
    output logic                          illegal
);

    localparam int unsigned SW = $clog2(2*WIDTH);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHUP  = 3'b001,
        M_SHDN  = 3'b010,
        M_LOAD  = 3'b011,
        M_ROTUP = 3'b100,
        M_ROTDN = 3'b101,
        M_JOHN  = 3'b110,
        M_RSVD  = 3'b111
    } mode_t;

    // Rotation mode that owns the current step count.
    typedef enum logic [1:0] {
        ROT_NONE,
        ROT_UP,
        ROT_DN,
        ROT_JOHN
    } rot_t;

    mode_t            mode_e;
    logic [WIDTH-1:0] q_q, q_d;
    logic [SW-1:0]    step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             illegal_q, illegal_d;
    rot_t             rot_q, rot_d;

    rot_t             rot_req;
    logic [WIDTH-1:0] rot_val;
    logic [SW-1:0]    period_m1;

    assign mode_e = mode_t'(mode);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RESET_VAL;
            step_q    <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            rot_q     <= ROT_NONE;
        end else begin
            q_q       <= q_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            rot_q     <= rot_d;
        end
    end

    always_comb begin
        q_d       = q_q;
        step_d    = step_q;
        wrap_d    = 1'b0;
        illegal_d = illegal_q;
        rot_d     = rot_q;
        rot_req   = ROT_NONE;
        rot_val   = q_q;
        period_m1 = '0;

        if (en) begin
            case (mode_e)
                M_HOLD: ;
                M_SHUP: begin
                    q_d    = {q_q[WIDTH-2:0], sin_up};
                    step_d = '0;
                    rot_d  = ROT_NONE;
                end
                M_SHDN: begin
                    q_d    = {sin_dn, q_q[WIDTH-1:1]};
                    step_d = '0;
                    rot_d  = ROT_NONE;
                end
                M_LOAD: begin
                    q_d    = load_val;
                    step_d = '0;
                    rot_d  = ROT_NONE;
                end
                M_ROTUP: begin
                    rot_req   = ROT_UP;
                    rot_val   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    period_m1 = SW'(WIDTH - 1);
                end
                M_ROTDN: begin
                    rot_req   = ROT_DN;
                    rot_val   = {q_q[0], q_q[WIDTH-1:1]};
                    period_m1 = SW'(WIDTH - 1);
                end
                M_JOHN: begin
                    rot_req   = ROT_JOHN;
                    rot_val   = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                    period_m1 = SW'(2*WIDTH - 1);
                end
                M_RSVD: illegal_d = 1'b1;
                default: ;
            endcase

            // Entering a different rotation mode restarts the count; that
            // first step already counts as step 1.
            if (rot_req != ROT_NONE) begin
                q_d = rot_val;
                if (rot_req != rot_q) begin
                    step_d = SW'(1);
                    rot_d  = rot_req;
                end else if (step_q == period_m1) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
        end
    end

    assign q       = q_q;
    assign sout_up = q_q[WIDTH-1];
    assign sout_dn = q_q[0];
    assign step    = step_q;
    assign wrap    = wrap_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_counter_n.sv
module tb_shift_counter_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_up = 1'b0;
    logic       sin_dn = 1'b0;
    logic [7:0] load_val = '0;

    logic [3:0] q4;
    logic       su4, sd4, wrap4, ill4;
    logic [2:0] step4;
    logic [7:0] q8;
    logic       su8, sd8, wrap8, ill8;
    logic [3:0] step8;

    always #5 clk = ~clk;

    shift_counter_n #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .sin_up(sin_up), .sin_dn(sin_dn), .load_val(load_val[3:0]),
        .q(q4), .sout_up(su4), .sout_dn(sd4), .step(step4),
        .wrap(wrap4), .illegal(ill4)
    );

    shift_counter_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .sin_up(sin_up), .sin_dn(sin_dn), .load_val(load_val),
        .q(q8), .sout_up(su8), .sout_dn(sd8), .step(step8),
        .wrap(wrap8), .illegal(ill8)
    );

    typedef struct {
        int         dut;   // 0: WIDTH=4 instance, 1: WIDTH=8 instance
        logic [7:0] q;
        int         step;
        logic       wrap;
        logic       ill;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: every cycle after the edge, pop one expectation and compare.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic [7:0] aq;
            int         as;
            logic       aw, ai, aup, adn, eup, edn;
            e = sb.pop_front();
            if (e.dut == 0) begin
                aq = {4'b0, q4}; as = int'(step4); aw = wrap4; ai = ill4;
                aup = su4; adn = sd4; eup = e.q[3];
            end else begin
                aq = q8; as = int'(step8); aw = wrap8; ai = ill8;
                aup = su8; adn = sd8; eup = e.q[7];
            end
            edn = e.q[0];
            checks++;
            if (aq !== e.q || as != e.step || aw !== e.wrap || ai !== e.ill ||
                aup !== eup || adn !== edn) begin
                errors++;
                $display("FAIL %s: got q=%b step=%0d wrap=%b illegal=%b sout_up=%b sout_dn=%b, want q=%b step=%0d wrap=%b illegal=%b sout_up=%b sout_dn=%b",
                         e.name, aq, as, aw, ai, aup, adn,
                         e.q, e.step, e.wrap, e.ill, eup, edn);
            end
        end
    end

    // Drive one cycle of stimulus and queue the value expected after the edge.
    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic su, input logic sd, input logic [7:0] lv,
                       input int d, input logic [7:0] xq, input int xs,
                       input logic xw, input logic xi, input string nm);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; mode = m; sin_up = su; sin_dn = sd; load_val = lv;
        x.dut = d; x.q = xq; x.step = xs; x.wrap = xw; x.ill = xi; x.name = nm;
        sb.push_back(x);
    endtask

    initial begin
        // Reset defaults
        cyc(1, 0, 3'b000, 0, 0, 8'h00, 0, 8'b1000, 0, 0, 0, "reset1");
        cyc(1, 1, 3'b110, 0, 0, 8'h00, 0, 8'b1000, 0, 0, 0, "reset2");
        cyc(0, 0, 3'b111, 0, 0, 8'h00, 0, 8'b1000, 0, 0, 0, "rsvd_en0");

        // Shift up
        cyc(0, 1, 3'b001, 1, 0, 8'h00, 0, 8'b0001, 0, 0, 0, "shup1");
        cyc(0, 1, 3'b001, 0, 0, 8'h00, 0, 8'b0010, 0, 0, 0, "shup2");
        cyc(0, 1, 3'b001, 1, 0, 8'h00, 0, 8'b0101, 0, 0, 0, "shup3");
        cyc(0, 1, 3'b001, 1, 0, 8'h00, 0, 8'b1011, 0, 0, 0, "shup4");

        // Ring wrap up then down
        cyc(0, 1, 3'b011, 0, 0, 8'h08, 0, 8'b1000, 0, 0, 0, "load1000");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0001, 1, 0, 0, "rotup1");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0010, 2, 0, 0, "rotup2");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0100, 3, 0, 0, "rotup3");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b1000, 0, 1, 0, "rotup4_wrap");
        cyc(0, 1, 3'b101, 0, 0, 8'h00, 0, 8'b0100, 1, 0, 0, "rotdn1");
        cyc(0, 1, 3'b101, 0, 0, 8'h00, 0, 8'b0010, 2, 0, 0, "rotdn2");
        cyc(0, 1, 3'b101, 0, 0, 8'h00, 0, 8'b0001, 3, 0, 0, "rotdn3");
        cyc(0, 1, 3'b101, 0, 0, 8'h00, 0, 8'b1000, 0, 1, 0, "rotdn4_wrap");
        cyc(0, 1, 3'b000, 0, 0, 8'h00, 0, 8'b1000, 0, 0, 0, "hold");

        // Johnson with an en=0 stall
        cyc(0, 1, 3'b011, 0, 0, 8'h00, 0, 8'b0000, 0, 0, 0, "load0000");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b0001, 1, 0, 0, "john1");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b0011, 2, 0, 0, "john2");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b0111, 3, 0, 0, "john3");
        cyc(0, 0, 3'b110, 0, 0, 8'h00, 0, 8'b0111, 3, 0, 0, "john_stall");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b1111, 4, 0, 0, "john4");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b1110, 5, 0, 0, "john5");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b1100, 6, 0, 0, "john6");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b1000, 7, 0, 0, "john7");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b0000, 0, 1, 0, "john8_wrap");

        // Mode switch and reset mid-rotation
        cyc(0, 1, 3'b011, 0, 0, 8'h08, 0, 8'b1000, 0, 0, 0, "load1000b");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0001, 1, 0, 0, "sw_rotup1");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0010, 2, 0, 0, "sw_rotup2");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b0101, 1, 0, 0, "sw_john1");
        cyc(1, 1, 3'b110, 0, 0, 8'h00, 0, 8'b1000, 0, 0, 0, "reset_mid");
        cyc(0, 1, 3'b110, 0, 0, 8'h00, 0, 8'b0000, 1, 0, 0, "john_after_rst");

        // Shift down, and HOLD between rotation steps
        cyc(0, 1, 3'b010, 0, 1, 8'h00, 0, 8'b1000, 0, 0, 0, "shdn1");
        cyc(0, 1, 3'b010, 0, 0, 8'h00, 0, 8'b0100, 0, 0, 0, "shdn2");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b1000, 1, 0, 0, "rot_a");
        cyc(0, 1, 3'b000, 0, 0, 8'h00, 0, 8'b1000, 1, 0, 0, "rot_hold");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0001, 2, 0, 0, "rot_b");

        // Reserved mode: sticky illegal, count context kept
        cyc(0, 1, 3'b111, 0, 0, 8'h00, 0, 8'b0001, 2, 0, 1, "rsvd");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0010, 3, 0, 1, "rsvd_rot1");
        cyc(0, 1, 3'b100, 0, 0, 8'h00, 0, 8'b0100, 0, 1, 1, "rsvd_rot_wrap");
        cyc(0, 1, 3'b011, 0, 0, 8'h0A, 0, 8'b1010, 0, 0, 1, "rsvd_load");
        cyc(1, 0, 3'b000, 0, 0, 8'h00, 0, 8'b1000, 0, 0, 0, "rsvd_reset");

        // WIDTH=8 instance: ring period 8
        cyc(1, 0, 3'b000, 0, 0, 8'h00, 1, 8'h80, 0, 0, 0, "w8_reset");
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] v;
            v = 8'h01 << (k - 1);
            if (k == 8) v = 8'h80;
            cyc(0, 1, 3'b100, 0, 0, 8'h00, 1, v, (k == 8) ? 0 : k,
                (k == 8), 0, $sformatf("w8_rotup%0d", k));
        end
        // WIDTH=8 Johnson period 16
        cyc(0, 1, 3'b011, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "w8_load0");
        for (int k = 1; k <= 16; k++) begin
            logic [7:0] v;
            v = (k <= 8) ? 8'((9'h001 << k) - 9'h001) : 8'(8'hFF << (k - 8));
            cyc(0, 1, 3'b110, 0, 0, 8'h00, 1, v, (k == 16) ? 0 : k,
                (k == 16), 0, $sformatf("w8_john%0d", k));
        end

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
